wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/mips_pkg.sv | 14 +
 rtl/wb_fwd_lookup.sv | 35 +++
 rtl/wb_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared datapath widths and write-back source encoding for the MIPS pipeline.
package mips_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 5;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the pending-write entries for operand forwarding.
module wb_fwd_lookup #(
    parameter int unsigned DATA_WIDTH    = mips_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = mips_pkg::ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 4,
    localparam int unsigned PTR_W        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                    valid_i,
    input  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_i,
    input  logic [PTR_W-1:0]                    head_i,
    input  logic [ADDRESS_WIDTH-1:0]            ra_i,
    output logic                                hit_o,
    output logic [DATA_WIDTH-1:0]               data_o
);
    import mips_pkg::*;

    logic [PTR_W-1:0] idx;

    // Walk from oldest (head) to youngest so the last match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (addr_i[idx] == ra_i) &&
                (ra_i != ADDRESS_WIDTH'(ZERO_REG))) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges MEM and ALU results in order into one register-file write port.
module wb_queue #(
    parameter int unsigned DATA_WIDTH    = mips_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = mips_pkg::ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     MemValid,
    output logic                     MemReady,
    input  logic [ADDRESS_WIDTH-1:0] MemRW,
    input  logic [DATA_WIDTH-1:0]    MemData,
    input  logic                     AluValid,
    output logic                     AluReady,
    input  logic [ADDRESS_WIDTH-1:0] AluRW,
    input  logic [DATA_WIDTH-1:0]    AluData,
    input  logic                     WbStall,
    output logic                     RegWr,
    output logic [ADDRESS_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0]    BusW,
    input  logic [ADDRESS_WIDTH-1:0] FwdRA,
    output logic                     FwdHit,
    output logic [DATA_WIDTH-1:0]    FwdData,
    output logic [$clog2(DEPTH):0]   Count
);
    import mips_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_q, data_d;
    logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                    count_q, count_d;

    logic [DEPTH-1:0]         valid;
    logic [PTR_W-1:0]         offset;
    wb_src_e                  src;
    logic [ADDRESS_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0]    push_data;
    logic                     push;
    logic                     pop;
    logic                     mem_ready;
    logic                     alu_ready;

    // Ready is deliberately not pop-aware: a full queue refuses even while draining.
    always_comb begin
        mem_ready = count_q < CNT_W'(DEPTH);
        alu_ready = mem_ready && !MemValid;
        src       = SRC_NONE;
        if (MemValid && mem_ready) begin
            src = SRC_MEM;
        end else if (AluValid && alu_ready) begin
            src = SRC_ALU;
        end
        push_addr = '0;
        push_data = '0;
        case (src)
            SRC_MEM: begin
                push_addr = MemRW;
                push_data = MemData;
            end
            SRC_ALU: begin
                push_addr = AluRW;
                push_data = AluData;
            end
            default: ;
        endcase
        push = (src != SRC_NONE) && (push_addr != ADDRESS_WIDTH'(ZERO_REG));
        pop  = (count_q != '0) && !WbStall;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr_q;
            valid[i] = {1'b0, offset} < count_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    wb_fwd_lookup #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DEPTH        (DEPTH)
    ) u_fwd_lookup (
        .valid_i(valid),
        .addr_i (addr_q),
        .data_i (data_q),
        .head_i (rd_ptr_q),
        .ra_i   (FwdRA),
        .hit_o  (FwdHit),
        .data_o (FwdData)
    );

    assign MemReady = mem_ready;
    assign AluReady = alu_ready;
    assign RegWr    = pop;
    assign RW       = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
    assign BusW     = (count_q != '0) ? data_q[rd_ptr_q] : '0;
    assign Count    = count_q;

endmodule
